iic_drive: RTL and testbench
============================

IIC_DRIVE -- requirements
Module: iic_drive

Interface
REQ-001 SHALL have parameter DEVICE_ADDR, default 7'b1010000, the 7-bit slave device address sent in every control byte.
REQ-002 SHALL have ports:
- iic_4_clk, input, 1 bit: system clock, 4x the SCL bit rate.
- rstn, input, 1 bit: reset.
REQ-003 SHALL use one clock, iic_4_clk; reset rstn is asynchronous and active-low.
REQ-004 SHALL have ports:
- iic_exec, input, 1 bit: start request, 1-cycle pulse.
- iic_rh_wl, input, 1 bit: 1 = random read, 0 = byte write.
- iic_bit_ctrl, input, 1 bit: 1 = 16-bit word address, 0 = 8-bit word address (iic_addr[7:0] only).
- iic_addr, input, 16 bits: word address.
- iic_data_w, input, 8 bits: write byte.
REQ-005 SHALL have ports:
- iic_done, output, 1 bit: 1-cycle completion pulse.
- iic_ack, output, 1 bit: 1 = a slave NACK occurred in the last transaction.
- iic_data_r, output, 8 bits: read byte.
- iic_busy, output, 1 bit: transaction in progress.
- scl, output, 1 bit: IIC clock.
- sda, inout, 1 bit: open-drain, drives 0 or Z only.

Function
REQ-006 SHALL sample iic_exec only in IDLE; it SHALL latch iic_rh_wl, iic_bit_ctrl, iic_addr and iic_data_w on that edge. iic_exec while busy is ignored.
REQ-007 SHALL time every bit as 4 phases (0..3):
- SCL: 0, 1, 1, 0.
- SDA updates in phase 0.
- Slave SDA is sampled in phase 2.
REQ-008 SHALL generate START in one 4-clock period: SDA released with SCL high, then SDA low while SCL is high (phase 2), then SCL low. REP_START SHALL do the same.
REQ-009 SHALL generate STOP in one 4-clock period: SDA low, SCL rises, then SDA released while SCL is high.
REQ-010 SHALL send bytes MSB first, each followed by a 9th ack bit with SDA released.
REQ-011 write sequence SHALL be: START, {DEVICE_ADDR,0}, ACK, [ADDR_H, ACK if iic_bit_ctrl], ADDR_L, ACK, DATA, ACK, STOP.
REQ-012 read sequence SHALL be: START, {DEVICE_ADDR,0}, ACK, [ADDR_H, ACK], ADDR_L, ACK, REP_START, {DEVICE_ADDR,1}, ACK, 8 data bits, master NACK (SDA released), STOP.
REQ-013 SHALL implement the FSM states IDLE, START, DEV_W, ADDR_H, ADDR_L, WR_DATA, REP_START, DEV_R, RD_DATA, MNACK, STOP, DONE. Byte states include their ack bit.
REQ-014 SHALL set iic_ack=1 if SDA reads 1 in any slave ack slot. iic_ack SHALL be cleared on acceptance of the next iic_exec.
REQ-015 SHALL update iic_data_r only on a completed read, in the same cycle as the iic_done pulse. It SHALL hold its value otherwise.
REQ-016 latency from the iic_exec sampling edge to the iic_done pulse (no abort) SHALL be:
- write, 16-bit address: 152 clocks.
- write, 8-bit address: 116 clocks.
- read, 16-bit address: 192 clocks.
- read, 8-bit address: 156 clocks.
REQ-017 iic_busy SHALL be 1 from the cycle after exec acceptance through the DONE cycle inclusive. iic_done SHALL be high exactly one cycle, in DONE. The FSM SHALL then return to IDLE.
REQ-018 back-to-back: iic_exec presented in the cycle after iic_done SHALL be accepted.

Reset
REQ-019 while rstn=0, outputs SHALL be:
- scl=1
- sda released (Z)
- iic_done=0
- iic_ack=0
- iic_data_r=8'h00
- iic_busy=0
The FSM SHALL be in IDLE and the phase and bit counters SHALL be 0.
REQ-020 reset asserted mid-transaction SHALL release the bus immediately (asynchronously), with no STOP generated. The first iic_exec after deassertion SHALL start a fresh transaction.

Configuration
REQ-021 macro IIC_NACK_ABORT_EN defined: a slave NACK SHALL jump to STOP at the next bit period, then DONE. iic_done still pulses and iic_ack=1.
REQ-022 macro IIC_NACK_ABORT_EN undefined: the transaction SHALL run its full length regardless of NACK, with latency per REQ-016. iic_ack still records the NACK.

Verification
REQ-023 write, iic_bit_ctrl=1, addr=16'h0123, data=8'hA5, slave always ACKs:
- SDA shows A0, 01, 23, A5 framed by START/STOP.
- iic_done at +152 clocks.
- iic_ack=0.
REQ-024 read, iic_bit_ctrl=0, addr=16'h0055, slave returns 8'h3C:
- SDA shows A0, 55, REP_START, A1, master NACK.
- iic_data_r=8'h3C with iic_done at +156.
REQ-025 write with slave NACK on the device byte:
- with IIC_NACK_ABORT_EN: STOP follows immediately, iic_done at +44, iic_ack=1.
- without it: iic_done at +152, iic_ack=1.
REQ-026 iic_exec pulsed at +50 during a busy write: ignored, no effect on SDA or latency. A second exec in the cycle after iic_done is accepted.
REQ-027 rstn low at clock 80 of a read:
- scl=1 and sda=Z within the same cycle.
- iic_busy=0 and iic_data_r=8'h00.
- After release, a write to 8'h10 completes in 116 clocks.

Source files
------------

// File: rtl/iic_drive.sv
// iic_drive: IIC master for single-byte write and random read transactions.
// Every bit takes four iic_4_clk cycles (phases 0..3, SCL = 0,1,1,0).
// Bus outputs are registered from the sequencer's state, so the pins show
// each phase one clock after the sequencer enters it; slave SDA is sampled
// on the edge that closes bus phase 2.
// Optional feature: define IIC_NACK_ABORT_EN to cut a transaction short
// (straight to STOP) after a slave NACK.
module iic_drive #(
  parameter logic [6:0] DEVICE_ADDR = 7'b1010000
) (
  input  logic        iic_4_clk,
  input  logic        rstn,
  input  logic        iic_exec,
  input  logic        iic_rh_wl,
  input  logic        iic_bit_ctrl,
  input  logic [15:0] iic_addr,
  input  logic [7:0]  iic_data_w,
  output logic        iic_done,
  output logic        iic_ack,
  output logic [7:0]  iic_data_r,
  output logic        iic_busy,
  output logic        scl,
  inout  wire         sda
);

`ifdef IIC_NACK_ABORT_EN
  localparam logic NACK_ABORT = 1'b1;
`else
  localparam logic NACK_ABORT = 1'b0;
`endif

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    START     = 4'd1,
    DEV_W     = 4'd2,
    ADDR_H    = 4'd3,
    ADDR_L    = 4'd4,
    WR_DATA   = 4'd5,
    REP_START = 4'd6,
    DEV_R     = 4'd7,
    RD_DATA   = 4'd8,
    MNACK     = 4'd9,
    STOP      = 4'd10,
    DONE      = 4'd11
  } state_t;

  state_t      state_r;
  logic [1:0]  phase_r;
  logic [3:0]  bit_r;
  logic        rh_wl_r;
  logic        bit_ctrl_r;
  logic [15:0] addr_r;
  logic [7:0]  data_w_r;
  logic [7:0]  rx_r;
  logic        rd_ok_r;
  logic        ack_r;
  logic        done_r;
  logic        busy_r;
  logic [7:0]  data_r_r;
  logic        scl_r;
  logic        sda_oe_r;

  logic [7:0]  tx_byte_s;
  logic        mid_phase_s;
  logic        scl_s;
  logic        sda_rel_s;
  logic        sda_in_s;
  state_t      next_byte_state_s;

  assign sda        = sda_oe_r ? 1'b0 : 1'bz;
  assign sda_in_s   = sda;
  assign scl        = scl_r;
  assign iic_done   = done_r;
  assign iic_ack    = ack_r;
  assign iic_busy   = busy_r;
  assign iic_data_r = data_r_r;

  // SCL is high in the middle two phases of every bit period
  assign mid_phase_s = phase_r[0] ^ phase_r[1];

  // Byte shifted out by the current byte state
  always_comb begin
    tx_byte_s = 8'h00;
    case (state_r)
      DEV_W:   tx_byte_s = {DEVICE_ADDR, 1'b0};
      ADDR_H:  tx_byte_s = addr_r[15:8];
      ADDR_L:  tx_byte_s = addr_r[7:0];
      WR_DATA: tx_byte_s = data_w_r;
      DEV_R:   tx_byte_s = {DEVICE_ADDR, 1'b1};
      default: tx_byte_s = 8'h00;
    endcase
  end

  // State that follows a byte state once its ack bit completes
  always_comb begin
    next_byte_state_s = IDLE;
    case (state_r)
      DEV_W:   next_byte_state_s = bit_ctrl_r ? ADDR_H : ADDR_L;
      ADDR_H:  next_byte_state_s = ADDR_L;
      ADDR_L:  next_byte_state_s = rh_wl_r ? REP_START : WR_DATA;
      WR_DATA: next_byte_state_s = STOP;
      DEV_R:   next_byte_state_s = RD_DATA;
      default: next_byte_state_s = IDLE;
    endcase
  end

  // Bus levels for the current state and phase (sda_rel_s = 1 releases SDA)
  always_comb begin
    scl_s     = 1'b1;
    sda_rel_s = 1'b1;
    case (state_r)
      START, REP_START: begin
        scl_s     = mid_phase_s;
        sda_rel_s = (phase_r < 2'd2);
      end
      STOP: begin
        scl_s     = (phase_r != 2'd0);
        sda_rel_s = (phase_r >= 2'd2);
      end
      DEV_W, ADDR_H, ADDR_L, WR_DATA, DEV_R: begin
        scl_s = mid_phase_s;
        if (bit_r[3]) begin
          sda_rel_s = 1'b1;
        end else begin
          sda_rel_s = tx_byte_s[3'd7 - bit_r[2:0]];
        end
      end
      RD_DATA, MNACK: begin
        scl_s     = mid_phase_s;
        sda_rel_s = 1'b1;
      end
      default: begin
        scl_s     = 1'b1;
        sda_rel_s = 1'b1;
      end
    endcase
  end

  // Transaction sequencer with registered bus pins and result registers
  always_ff @(posedge iic_4_clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= IDLE;
      phase_r    <= 2'd0;
      bit_r      <= 4'd0;
      rh_wl_r    <= 1'b0;
      bit_ctrl_r <= 1'b0;
      addr_r     <= 16'h0000;
      data_w_r   <= 8'h00;
      rx_r       <= 8'h00;
      rd_ok_r    <= 1'b0;
      ack_r      <= 1'b0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
      data_r_r   <= 8'h00;
      scl_r      <= 1'b1;
      sda_oe_r   <= 1'b0;
    end else begin
      scl_r    <= scl_s;
      sda_oe_r <= ~sda_rel_s;
      done_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (iic_exec) begin
            rh_wl_r    <= iic_rh_wl;
            bit_ctrl_r <= iic_bit_ctrl;
            addr_r     <= iic_addr;
            data_w_r   <= iic_data_w;
            ack_r      <= 1'b0;
            rd_ok_r    <= 1'b0;
            busy_r     <= 1'b1;
            phase_r    <= 2'd0;
            bit_r      <= 4'd0;
            state_r    <= START;
          end else begin
            state_r <= IDLE;
          end
        end
        DONE: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          phase_r <= phase_r + 2'd1;
          if (phase_r == 2'd3) begin
            case (state_r)
              START: begin
                bit_r   <= 4'd0;
                state_r <= DEV_W;
              end
              REP_START: begin
                bit_r   <= 4'd0;
                state_r <= DEV_R;
              end
              DEV_W, ADDR_H, ADDR_L, WR_DATA, DEV_R: begin
                if (!bit_r[3]) begin
                  bit_r <= bit_r + 4'd1;
                end else begin
                  // Ack slot: a released (high) line is a slave NACK
                  bit_r <= 4'd0;
                  if (sda_in_s) begin
                    ack_r <= 1'b1;
                  end
                  if (sda_in_s && NACK_ABORT) begin
                    state_r <= STOP;
                  end else begin
                    state_r <= next_byte_state_s;
                  end
                end
              end
              RD_DATA: begin
                rx_r <= {rx_r[6:0], sda_in_s};
                if (bit_r == 4'd7) begin
                  bit_r   <= 4'd0;
                  rd_ok_r <= 1'b1;
                  state_r <= MNACK;
                end else begin
                  bit_r <= bit_r + 4'd1;
                end
              end
              MNACK: begin
                state_r <= STOP;
              end
              STOP: begin
                done_r  <= 1'b1;
                state_r <= DONE;
                if (rd_ok_r) begin
                  data_r_r <= rx_r;
                end
              end
              default: begin
                state_r <= IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iic_drive.sv
// Directed bench for iic_drive with a behavioural IIC slave/bus monitor.
// Bus event log codes: 256 = START, 257 = STOP, 0..255 = byte seen on SDA.
module tb_iic_drive;

  logic        clk;
  logic        rstn;
  logic        iic_exec;
  logic        iic_rh_wl;
  logic        iic_bit_ctrl;
  logic [15:0] iic_addr;
  logic [7:0]  iic_data_w;
  logic        iic_done;
  logic        iic_ack;
  logic [7:0]  iic_data_r;
  logic        iic_busy;
  logic        scl;
  wire         sda;

  int errors = 0;
  int checks = 0;

  // slave model state
  logic       slave_low = 1'b0;
  logic       s_in_frame = 1'b0;
  logic       s_skip = 1'b0;
  logic       s_read = 1'b0;
  logic       s_mnack;
  logic [7:0] s_rx = 8'h00;
  logic [7:0] s_tx = 8'h00;
  logic       s_nack_dev = 1'b0;
  logic       prev_scl;
  logic       prev_sda;
  int         s_bit = 0;
  int         s_byte = 0;
  int         ev_q[$];

  wire sda_line = (sda === 1'b0) ? 1'b0 : 1'b1;

  pullup (sda);
  assign sda = (slave_low && rstn) ? 1'b0 : 1'bz;

  iic_drive #(.DEVICE_ADDR(7'b1010000)) dut (
    .iic_4_clk   (clk),
    .rstn        (rstn),
    .iic_exec    (iic_exec),
    .iic_rh_wl   (iic_rh_wl),
    .iic_bit_ctrl(iic_bit_ctrl),
    .iic_addr    (iic_addr),
    .iic_data_w  (iic_data_w),
    .iic_done    (iic_done),
    .iic_ack     (iic_ack),
    .iic_data_r  (iic_data_r),
    .iic_busy    (iic_busy),
    .scl         (scl),
    .sda         (sda)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave: detects START/STOP, logs bytes, acks, serves one read byte
  always @(scl or sda_line or rstn) begin
    if (!rstn) begin
      s_in_frame = 1'b0;
      slave_low  = 1'b0;
    end else if (scl === 1'b1 && prev_scl === 1'b1 && prev_sda === 1'b1 && sda_line === 1'b0) begin
      if (!s_in_frame) ev_q.delete();
      ev_q.push_back(256);
      s_in_frame = 1'b1;
      s_skip = 1'b1;
      s_bit = 0;
      s_byte = 0;
      s_read = 1'b0;
    end else if (scl === 1'b1 && prev_scl === 1'b1 && prev_sda === 1'b0 && sda_line === 1'b1) begin
      if (s_in_frame) ev_q.push_back(257);
      s_in_frame = 1'b0;
    end else if (prev_scl === 1'b0 && scl === 1'b1) begin
      if (s_in_frame) begin
        if (s_bit == 8) begin
          if (s_read && s_byte == 1) s_mnack = sda_line;
        end else begin
          s_rx = {s_rx[6:0], sda_line};
        end
      end
    end else if (prev_scl === 1'b1 && scl === 1'b0) begin
      if (s_in_frame) begin
        if (s_skip) begin
          s_skip = 1'b0;
        end else if (s_bit < 7) begin
          s_bit = s_bit + 1;
          if (s_read && s_byte == 1) slave_low = !s_tx[7 - s_bit];
        end else if (s_bit == 7) begin
          s_bit = 8;
          ev_q.push_back(int'(s_rx));
          if (s_read && s_byte == 1) begin
            slave_low = 1'b0;
          end else begin
            if (s_byte == 0 && s_rx[0]) s_read = 1'b1;
            slave_low = !(s_nack_dev && s_byte == 0 && !s_read);
          end
        end else begin
          s_bit = 0;
          s_byte = s_byte + 1;
          if (s_read && s_byte == 1) slave_low = !s_tx[7];
          else slave_low = 1'b0;
        end
      end
    end
    prev_scl = scl;
    prev_sda = sda_line;
  end

  // Index of first difference between the bus log and exp_q (-1 equal, -2 length)
  function automatic int log_diff(input int exp_q[$]);
    if (ev_q.size() != exp_q.size()) return -2;
    foreach (exp_q[i]) begin
      if (ev_q[i] != exp_q[i]) return i;
    end
    return -1;
  endfunction

  // Pulse iic_exec, optionally re-pulse it at cycle 'inject', count cycles to iic_done
  task automatic run_txn(input logic rh, input logic bc, input logic [15:0] a,
                         input logic [7:0] d, input int inject,
                         output int lat, output logic busy1);
    @(negedge clk);
    iic_rh_wl = rh;
    iic_bit_ctrl = bc;
    iic_addr = a;
    iic_data_w = d;
    iic_exec = 1'b1;
    @(posedge clk);
    #1;
    busy1 = iic_busy;
    iic_exec = 1'b0;
    iic_rh_wl = ~rh;
    iic_bit_ctrl = ~bc;
    iic_addr = ~a;
    iic_data_w = ~d;
    lat = -1;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      iic_exec = (c == inject);
      @(posedge clk);
      #1;
      if (iic_done) begin
        lat = c;
        break;
      end
    end
    iic_exec = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (scl !== 1'b1) begin errors++; $display("FAIL rst_scl: got %b want 1", scl); end
    checks++; if (sda_line !== 1'b1) begin errors++; $display("FAIL rst_sda: got %b want released", sda_line); end
    checks++; if (iic_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", iic_done); end
    checks++; if (iic_ack !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b want 0", iic_ack); end
    checks++; if (iic_data_r !== 8'h00) begin errors++; $display("FAIL rst_data_r: got %h want 00", iic_data_r); end
    checks++; if (iic_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", iic_busy); end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write16();
    int lat;
    logic b1;
    int d;
    int exp_q[$];
    s_nack_dev = 1'b0;
    run_txn(1'b0, 1'b1, 16'h0123, 8'hA5, 0, lat, b1);
    exp_q = '{256, 32'hA0, 32'h01, 32'h23, 32'hA5, 257};
    checks++; if (lat !== 152) begin errors++; $display("FAIL wr16_latency: got %0d want 152", lat); end
    checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL wr16_busy: got %b want 1", b1); end
    checks++; if (iic_ack !== 1'b0) begin errors++; $display("FAIL wr16_ack: got %b want 0", iic_ack); end
    d = log_diff(exp_q);
    checks++; if (d !== -1) begin errors++; $display("FAIL wr16_sda: log differs at %0d (-2 length), got %0d events want %0d", d, ev_q.size(), exp_q.size()); end
    @(posedge clk);
    #1;
    checks++; if (iic_done !== 1'b0) begin errors++; $display("FAIL wr16_done_width: got %b want 0", iic_done); end
    checks++; if (iic_busy !== 1'b0) begin errors++; $display("FAIL wr16_busy_end: got %b want 0", iic_busy); end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_read8();
    int lat;
    logic b1;
    int d;
    int exp_q[$];
    s_tx = 8'h3C;
    run_txn(1'b1, 1'b0, 16'h0055, 8'h00, 0, lat, b1);
    exp_q = '{256, 32'hA0, 32'h55, 256, 32'hA1, 32'h3C, 257};
    checks++; if (lat !== 156) begin errors++; $display("FAIL rd8_latency: got %0d want 156", lat); end
    checks++; if (iic_data_r !== 8'h3C) begin errors++; $display("FAIL rd8_data: got %h want 3c", iic_data_r); end
    checks++; if (iic_ack !== 1'b0) begin errors++; $display("FAIL rd8_ack: got %b want 0", iic_ack); end
    checks++; if (s_mnack !== 1'b1) begin errors++; $display("FAIL rd8_master_nack: got %b want 1", s_mnack); end
    d = log_diff(exp_q);
    checks++; if (d !== -1) begin errors++; $display("FAIL rd8_sda: log differs at %0d (-2 length), got %0d events want %0d", d, ev_q.size(), exp_q.size()); end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_read16();
    int lat;
    logic b1;
    int d;
    int exp_q[$];
    s_tx = 8'h5A;
    run_txn(1'b1, 1'b1, 16'hBEEF, 8'h00, 0, lat, b1);
    exp_q = '{256, 32'hA0, 32'hBE, 32'hEF, 256, 32'hA1, 32'h5A, 257};
    checks++; if (lat !== 192) begin errors++; $display("FAIL rd16_latency: got %0d want 192", lat); end
    checks++; if (iic_data_r !== 8'h5A) begin errors++; $display("FAIL rd16_data: got %h want 5a", iic_data_r); end
    d = log_diff(exp_q);
    checks++; if (d !== -1) begin errors++; $display("FAIL rd16_sda: log differs at %0d (-2 length), got %0d events want %0d", d, ev_q.size(), exp_q.size()); end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_nack();
    int lat;
    logic b1;
    int d;
    int exp_lat;
    int exp_q[$];
    s_nack_dev = 1'b1;
    run_txn(1'b0, 1'b1, 16'h0123, 8'hA5, 0, lat, b1);
`ifdef IIC_NACK_ABORT_EN
    exp_lat = 44;
    exp_q = '{256, 32'hA0, 257};
`else
    exp_lat = 152;
    exp_q = '{256, 32'hA0, 32'h01, 32'h23, 32'hA5, 257};
`endif
    checks++; if (lat !== exp_lat) begin errors++; $display("FAIL nack_latency: got %0d want %0d", lat, exp_lat); end
    checks++; if (iic_ack !== 1'b1) begin errors++; $display("FAIL nack_ack: got %b want 1", iic_ack); end
    checks++; if (iic_data_r !== 8'h5A) begin errors++; $display("FAIL nack_data_hold: got %h want 5a", iic_data_r); end
    d = log_diff(exp_q);
    checks++; if (d !== -1) begin errors++; $display("FAIL nack_sda: log differs at %0d (-2 length), got %0d events want %0d", d, ev_q.size(), exp_q.size()); end
    s_nack_dev = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_back_to_back();
    int lat;
    logic b1;
    int d;
    int exp_q[$];
    run_txn(1'b0, 1'b1, 16'h0123, 8'hA5, 50, lat, b1);
    exp_q = '{256, 32'hA0, 32'h01, 32'h23, 32'hA5, 257};
    checks++; if (lat !== 152) begin errors++; $display("FAIL busy_exec_latency: got %0d want 152", lat); end
    checks++; if (iic_ack !== 1'b0) begin errors++; $display("FAIL busy_exec_ack_cleared: got %b want 0", iic_ack); end
    d = log_diff(exp_q);
    checks++; if (d !== -1) begin errors++; $display("FAIL busy_exec_sda: log differs at %0d (-2 length), got %0d events want %0d", d, ev_q.size(), exp_q.size()); end
    @(posedge clk);
    run_txn(1'b0, 1'b0, 16'h0042, 8'h3C, 0, lat, b1);
    exp_q = '{256, 32'hA0, 32'h42, 32'h3C, 257};
    checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL b2b_accept: busy got %b want 1", b1); end
    checks++; if (lat !== 116) begin errors++; $display("FAIL b2b_latency: got %0d want 116", lat); end
    d = log_diff(exp_q);
    checks++; if (d !== -1) begin errors++; $display("FAIL b2b_sda: log differs at %0d (-2 length), got %0d events want %0d", d, ev_q.size(), exp_q.size()); end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    int lat;
    logic b1;
    int d;
    int exp_q[$];
    s_tx = 8'hC3;
    @(negedge clk);
    iic_rh_wl = 1'b1;
    iic_bit_ctrl = 1'b0;
    iic_addr = 16'h0055;
    iic_data_w = 8'h00;
    iic_exec = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iic_exec = 1'b0;
    repeat (79) @(posedge clk);
    #2;
    checks++; if (iic_busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b want 1", iic_busy); end
    rstn = 1'b0;
    #1;
    checks++; if (scl !== 1'b1) begin errors++; $display("FAIL midrst_scl: got %b want 1", scl); end
    checks++; if (sda_line !== 1'b1) begin errors++; $display("FAIL midrst_sda: got %b want released", sda_line); end
    checks++; if (iic_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", iic_busy); end
    checks++; if (iic_data_r !== 8'h00) begin errors++; $display("FAIL midrst_data_r: got %h want 00", iic_data_r); end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    run_txn(1'b0, 1'b0, 16'h0010, 8'h77, 0, lat, b1);
    exp_q = '{256, 32'hA0, 32'h10, 32'h77, 257};
    checks++; if (lat !== 116) begin errors++; $display("FAIL midrst_wr8_latency: got %0d want 116", lat); end
    checks++; if (iic_ack !== 1'b0) begin errors++; $display("FAIL midrst_wr8_ack: got %b want 0", iic_ack); end
    d = log_diff(exp_q);
    checks++; if (d !== -1) begin errors++; $display("FAIL midrst_wr8_sda: log differs at %0d (-2 length), got %0d events want %0d", d, ev_q.size(), exp_q.size()); end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    rstn = 1'b0;
    iic_exec = 1'b0;
    iic_rh_wl = 1'b0;
    iic_bit_ctrl = 1'b0;
    iic_addr = 16'h0000;
    iic_data_w = 8'h00;
    test_reset();
    test_write16();
    test_read8();
    test_read16();
    test_nack();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
